m68k_bus_master: RTL
====================

Name: m68k_bus_master

Overview:
- 68000-style asynchronous bus cycle initiator. Drives the address, _AS, _UDS/_LDS and R_W lines, and terminates each cycle on _DTACK or _BERR.
- It is the requesting end of the bus that the ROM/DTACK decode logic responds to. Used by bench masters and by future soft-CPU/DMA front ends.
- One CLK period equals one 68000 S-state, so CLK runs at twice the CPU bus clock.

Parameters:
TIMEOUT_CYCLES, 64, S4 wait cycles before a forced bus error (used only with M68K_BUS_TIMEOUT_EN; legal range 1..255)

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
REQ  in  1  request strobe; sampled only in IDLE
WE  in  1  1 = write cycle, 0 = read cycle
BE  in  2  byte enables; bit1 = upper (D15..8), bit0 = lower (D7..0)
ADDR  in  23  word address, maps to A23..A1
WDATA  in  16  write data
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle completion pulse
ERR  out  1  valid with DONE; 1 = bus error or illegal request
RDATA  out  16  read data; held until the next successful read
A  out  23  bus address A23..A1
_AS  out  1  address strobe, active low
_UDS  out  1  upper data strobe, active low
_LDS  out  1  lower data strobe, active low
R_W  out  1  1 = read, 0 = write
D_OUT  out  16  bus write data
D_OE  out  1  data bus output enable
D_IN  in  16  bus read data
_DTACK  in  1  data acknowledge, active low, synchronous to CLK
_BERR  in  1  bus error, active low, synchronous to CLK

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high.
- Reset values: state IDLE; BUSY=0, DONE=0, ERR=0, RDATA=0, A=0, _AS=1, _UDS=1, _LDS=1, R_W=1, D_OUT=0, D_OE=0.
- States: IDLE, S0, S1, S2, S3, S4, S5, S6, S7, BAD. All outputs are registered and reflect the current state.
- IDLE:
  - REQ=1 with BE!=00: capture ADDR/WE/BE/WDATA, go to S0.
  - REQ=1 with BE=00: go to BAD.
  - REQ is ignored in every other state.
- BAD: one cycle with DONE=1, ERR=1, no bus activity; then IDLE.
- Address lines: A is driven from S0 through S7 and holds its last value in IDLE.
- Strobes by state:
  - S2..S6: _AS=0.
  - Read: the selected _UDS/_LDS are low S2..S6.
  - Write: R_W=0 S2..S7; D_OE=1 S3..S7 with D_OUT=WDATA; selected strobes low S4..S6.
  - Unselected strobes stay 1 throughout.
- Fixed sequencing: S0→S1→S2→S3→S4.
- S4 exit, sampled at the end of each S4 cycle (_BERR has priority):
  - _BERR=0: go to S7 with the error flag set.
  - else _DTACK=0: go to S5.
  - else: stay in S4 (one wait state per extra cycle).
- S5→S6. At the end of S6 on a read, RDATA <= D_IN.
- S7: _AS/_UDS/_LDS=1, DONE=1, ERR=error flag. Next state is IDLE, with R_W=1 and D_OE=0 there.
- Latency: a zero-wait cycle accepted at edge 0 shows DONE in cycle 8, so the minimum period is 9 CLKs request-to-request. Each wait state adds one.
- On a bus error, RDATA is not updated.
- Reset during any state: outputs take reset values on the next edge, no DONE is produced, and the in-flight request is discarded.

Optional Feature:
- Macro: M68K_BUS_TIMEOUT_EN.
- With it defined:
  - An 8-bit counter clears on entry to S4 and increments on each S4 wait cycle.
  - If the counter reaches TIMEOUT_CYCLES with neither _DTACK nor _BERR low, the block behaves exactly as if _BERR had been sampled low: S7 with ERR=1.
- Without it: no counter exists and S4 waits indefinitely.

Test Plan:
1. Zero-wait read: ADDR=0x3F8000, BE=11, WE=0, _DTACK=0, D_IN=0x1234, REQ at edge 0 -> _AS/_UDS/_LDS low cycles 3..7, DONE=1 ERR=0 in cycle 8, RDATA=0x1234, BUSY=0 in cycle 9.
2. Byte write with 3 waits: WE=1, BE=01, WDATA=0x00A5, _DTACK low from the 4th S4 cycle -> _LDS low S4..S6, _UDS=1, R_W=0, D_OE=1, D_OUT=0x00A5, DONE in cycle 11.
3. Bus error: read, _BERR=0 in first S4 -> S7 next cycle, DONE=1 ERR=1 in cycle 6, RDATA unchanged from the previous value.
4. Timeout (macro defined, TIMEOUT_CYCLES=16, _DTACK and _BERR held 1) -> DONE with ERR=1 after 16 S4 cycles. Same stimulus without the macro -> BUSY=1 and _AS=0 held for 1000 cycles.
5. Reset mid-cycle: RESET=1 while in S4 -> next cycle _AS=1, R_W=1, D_OE=0, BUSY=0; no DONE for 20 cycles.
6. Illegal request: REQ with BE=00 -> DONE=1 ERR=1 in cycle 1, _AS never low; a following valid request completes normally.

Source files
------------

// File: rtl/m68k_bus_master_if.sv
// Request side and 68000 bus side of m68k_bus_master, grouped into one bundle.
// master: the bus initiator. slave: the requester together with the bus
// responder (ROM/DTACK decode, bench models).
interface m68k_bus_master_if;
  // request side
  logic        req;
  logic        we;
  logic [1:0]  be;
  logic [22:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rdata;
  // 68000 bus side
  logic [22:0] a;
  logic        as_n;
  logic        uds_n;
  logic        lds_n;
  logic        r_w;
  logic [15:0] d_out;
  logic        d_oe;
  logic [15:0] d_in;
  logic        dtack_n;
  logic        berr_n;

  modport master (
    input  req, we, be, addr, wdata, d_in, dtack_n, berr_n,
    output busy, done, err, rdata, a, as_n, uds_n, lds_n, r_w, d_out, d_oe
  );

  modport slave (
    output req, we, be, addr, wdata, d_in, dtack_n, berr_n,
    input  busy, done, err, rdata, a, as_n, uds_n, lds_n, r_w, d_out, d_oe
  );
endinterface

// File: rtl/m68k_bus_master.sv
// 68000-style asynchronous bus cycle initiator. One clk_i period is one
// S-state. Every output is registered and follows the current state.
// Optional macro M68K_BUS_TIMEOUT_EN: forces a bus error after TIMEOUT_CYCLES
// S4 cycles with no _DTACK/_BERR; without it S4 waits indefinitely.
//
// state | meaning
// IDLE  | waiting for req; A holds its last value
// S0-S1 | address phase, strobes inactive
// S2-S3 | _AS low (read strobes low, write R_W low / D_OE from S3)
// S4    | wait for _DTACK or _BERR (_BERR wins)
// S5-S6 | acknowledged; read data captured at the end of S6
// S7    | strobes released, DONE/ERR pulse
// BAD   | req with no byte enables: DONE+ERR, no bus activity
module m68k_bus_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk_i,
  input logic rst_i,
  m68k_bus_master_if.master bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [3:0] {
    ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7, ST_BAD
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_flag_q, err_flag_d;
  logic        timeout_hit;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] rdata_q, rdata_d;
  logic [22:0] a_q, a_d;
  logic        as_n_q, as_n_d;
  logic        uds_n_q, uds_n_d;
  logic        lds_n_q, lds_n_d;
  logic        rw_q, rw_d;
  logic [15:0] dout_q, dout_d;
  logic        doe_q, doe_d;

  logic        win_rd, win_wr, strobe_on;

`ifdef M68K_BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q;

  // S4 wait counter: cleared on the way into S4, counts cycles spent waiting
  always_ff @(posedge clk_i) begin
    if (rst_i)                                  tmo_cnt_q <= '0;
    else if (state_q == ST_S3)                  tmo_cnt_q <= '0;
    else if (state_q == ST_S4 && state_d == ST_S4) tmo_cnt_q <= tmo_cnt_q + 8'd1;
  end

  assign timeout_hit = (tmo_cnt_q == TMO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // state and captured request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      be_q       <= 2'b00;
      wdata_q    <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      err_flag_q <= err_flag_d;
    end
  end

  // next state, request capture, and next value of every registered output
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    a_d        = a_q;
    err_flag_d = err_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          if (bus.be != 2'b00) begin
            state_d    = ST_S0;
            we_d       = bus.we;
            be_d       = bus.be;
            wdata_d    = bus.wdata;
            a_d        = bus.addr;
            err_flag_d = 1'b0;
          end else begin
            state_d = ST_BAD;
          end
        end
      end
      ST_S0: state_d = ST_S1;
      ST_S1: state_d = ST_S2;
      ST_S2: state_d = ST_S3;
      ST_S3: state_d = ST_S4;
      ST_S4: begin
        if (!bus.berr_n || (bus.dtack_n && timeout_hit)) begin
          state_d    = ST_S7;
          err_flag_d = 1'b1;
        end else if (!bus.dtack_n) begin
          state_d = ST_S5;
        end
      end
      ST_S5:   state_d = ST_S6;
      ST_S6:   state_d = ST_S7;
      ST_S7:   state_d = ST_IDLE;
      ST_BAD:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    win_rd = (state_d == ST_S2) || (state_d == ST_S3) || (state_d == ST_S4) ||
             (state_d == ST_S5) || (state_d == ST_S6);
    win_wr = (state_d == ST_S4) || (state_d == ST_S5) || (state_d == ST_S6);
    strobe_on = we_d ? win_wr : win_rd;

    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_S7) || (state_d == ST_BAD);
    err_d   = (state_d == ST_BAD) || ((state_d == ST_S7) && err_flag_d);
    as_n_d  = !win_rd;
    uds_n_d = !(strobe_on && be_d[1]);
    lds_n_d = !(strobe_on && be_d[0]);
    rw_d    = !(we_d && (win_rd || state_d == ST_S7));
    doe_d   = we_d && ((state_d == ST_S3) || win_wr || (state_d == ST_S7));
    dout_d  = doe_d ? wdata_d : dout_q;
    // read data is taken at the end of S6 only; a bus error never reaches S6
    rdata_d = (state_q == ST_S6 && !we_q) ? bus.d_in : rdata_q;
  end

  // registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      a_q     <= '0;
      as_n_q  <= 1'b1;
      uds_n_q <= 1'b1;
      lds_n_q <= 1'b1;
      rw_q    <= 1'b1;
      dout_q  <= '0;
      doe_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      a_q     <= a_d;
      as_n_q  <= as_n_d;
      uds_n_q <= uds_n_d;
      lds_n_q <= lds_n_d;
      rw_q    <= rw_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign bus.a     = a_q;
  assign bus.as_n  = as_n_q;
  assign bus.uds_n = uds_n_q;
  assign bus.lds_n = lds_n_q;
  assign bus.r_w   = rw_q;
  assign bus.d_out = dout_q;
  assign bus.d_oe  = doe_q;

endmodule
